// File: rtl/block_acc_pkg.sv
// rtl/block_acc_pkg.sv - shared types and constants for the block accumulator
// Purpose: state encoding (ACC, HOLD) and the out_cnt width used by block_accumulator.
// Ports: none (package).
package block_acc_pkg;

   localparam int CNT_W = 16;

   typedef enum logic {
      ACC  = 1'b0,
      HOLD = 1'b1
   } acc_state_t;

endpackage

// File: rtl/acc_add_sat.sv
// rtl/acc_add_sat.sv - W-bit adder with carry-out and optional saturating clamp
// Purpose: adds running sum a and sample b. With BLOCK_ACC_SAT_EN defined a carry
//          clamps sum to all-ones; otherwise sum wraps modulo 2**W.
// Ports:
//   a     in  W  running sum
//   b     in  W  zero-extended sample
//   sum   out W  wrapped or clamped result
//   carry out 1  carry out of bit W-1 (overflow)
// Config macro: BLOCK_ACC_SAT_EN
module acc_add_sat #(
   parameter int W = 20
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] sum,
   output logic         carry
);

   logic [W:0] full;

   assign full  = {1'b0, a} + {1'b0, b};
   assign carry = full[W];

`ifdef BLOCK_ACC_SAT_EN
   // Once saturated, any further nonzero sample carries again and a zero sample
   // leaves all-ones unchanged, so the sum stays pinned for the rest of the block.
   assign sum = carry ? {W{1'b1}} : full[W-1:0];
`else
   assign sum = full[W-1:0];
`endif

endmodule

// File: rtl/block_accumulator.sv
// rtl/block_accumulator.sv - sums fixed-length blocks of unsigned samples
// Purpose: accumulates BLK_LEN samples (or fewer on flush) and holds the block
//          sum, sample count and overflow flag until the consumer takes it.
// Ports:
//   clk        in  1      clock, rising edge
//   rst        in  1      synchronous active-high reset
//   ce         in  1      clock enable; low freezes everything
//   in_valid   in  1      sample A present
//   in_ready   out 1      sample can be accepted (accumulating)
//   A          in  IN_W   unsigned sample
//   flush      in  1      dump a non-empty partial block
//   out_valid  out 1      result held
//   out_ready  in  1      consumer takes result
//   Y          out OUT_W  block sum
//   out_cnt    out 16     samples in Y
//   out_ovf    out 1      overflow occurred in this block
// Config macro: BLOCK_ACC_SAT_EN (saturate instead of wrap, in acc_add_sat)
module block_accumulator
   import block_acc_pkg::*;
#(
   parameter int IN_W    = 13,
   parameter int OUT_W   = 20,
   parameter int BLK_LEN = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ce,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  A,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] Y,
   output logic [CNT_W-1:0] out_cnt,
   output logic             out_ovf
);

   if (OUT_W < IN_W) begin : g_bad_out_w
      $error("block_accumulator: OUT_W must be >= IN_W");
   end
   if (BLK_LEN < 2 || BLK_LEN > 65535) begin : g_bad_blk_len
      $error("block_accumulator: BLK_LEN must be in 2..65535");
   end

   acc_state_t       state, state_nxt;
   logic [OUT_W-1:0] acc;
   logic [CNT_W-1:0] cnt;
   logic             ovf;

   logic [OUT_W-1:0] a_ext, sum_add, sum_fin;
   logic             carry;
   logic [CNT_W-1:0] cnt_inc, cnt_fin;
   logic             ovf_fin;
   logic             accept, close_blk, release_out;

   assign in_ready  = (state == ACC);
   assign out_valid = (state == HOLD);

   assign a_ext   = OUT_W'(A);
   assign accept  = ce & in_valid & in_ready;
   assign cnt_inc = cnt + CNT_W'(1);

   acc_add_sat #(.W(OUT_W)) u_add (
      .a     (acc),
      .b     (a_ext),
      .sum   (sum_add),
      .carry (carry)
   );

   // Block totals including this cycle's sample, if one is accepted.
   always_comb begin
      sum_fin = acc;
      cnt_fin = cnt;
      ovf_fin = ovf;
      if (accept) begin
         sum_fin = sum_add;
         cnt_fin = cnt_inc;
         ovf_fin = ovf | carry;
      end
   end

   // A block closes on its last sample, or on flush when it would not be empty.
   assign close_blk = ce & in_ready &
                      ((accept & (cnt_inc == CNT_W'(BLK_LEN))) |
                       (flush & ((cnt != '0) | accept)));

   assign release_out = ce & out_valid & out_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ACC;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ACC:     if (close_blk)   state_nxt = HOLD;
         HOLD:    if (release_out) state_nxt = ACC;
         default: state_nxt = ACC;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc     <= '0;
         cnt     <= '0;
         ovf     <= 1'b0;
         Y       <= '0;
         out_cnt <= '0;
         out_ovf <= 1'b0;
      end else if (close_blk) begin
         Y       <= sum_fin;
         out_cnt <= cnt_fin;
         out_ovf <= ovf_fin;
         acc     <= '0;
         cnt     <= '0;
         ovf     <= 1'b0;
      end else if (accept) begin
         acc <= sum_fin;
         cnt <= cnt_fin;
         ovf <= ovf_fin;
      end
   end

endmodule

// File: tb/tb_block_accumulator.sv
// tb/tb_block_accumulator.sv - scoreboard bench for block_accumulator
// Purpose: directed sample streams; expected block results are queued at stimulus
//          time and checked by independent monitors on out_valid.
// Ports: none. Config macro: BLOCK_ACC_SAT_EN selects the saturating expectation.
module tb_block_accumulator;

   typedef struct {
      int y;
      int cnt;
      int ovf;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ce = 1'b1;

   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [12:0] a = '0;
   logic        flush = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [19:0] y;
   logic [15:0] out_cnt;
   logic        out_ovf;

   logic        in_valid14 = 1'b0;
   logic        in_ready14;
   logic [12:0] a14 = '0;
   logic        out_valid14;
   logic [13:0] y14;
   logic [15:0] out_cnt14;
   logic        out_ovf14;

   int   total = 0;
   int   bad = 0;
   exp_t q[$];
   exp_t q14[$];

   always #5 clk = ~clk;

   block_accumulator dut (
      .clk       (clk),
      .rst       (rst),
      .ce        (ce),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .A         (a),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .Y         (y),
      .out_cnt   (out_cnt),
      .out_ovf   (out_ovf)
   );

   block_accumulator #(.IN_W(13), .OUT_W(14), .BLK_LEN(10)) dut14 (
      .clk       (clk),
      .rst       (rst),
      .ce        (ce),
      .in_valid  (in_valid14),
      .in_ready  (in_ready14),
      .A         (a14),
      .flush     (1'b0),
      .out_valid (out_valid14),
      .out_ready (1'b1),
      .Y         (y14),
      .out_cnt   (out_cnt14),
      .out_ovf   (out_ovf14)
   );

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic exp_t mk(input int yv, input int cv, input int ov);
      exp_t e;
      e.y = yv;
      e.cnt = cv;
      e.ovf = ov;
      return e;
   endfunction

   // Present a sample (optionally with flush) until accepted, bounded.
   task automatic send(input logic [12:0] v, input logic fl);
      int n;
      n = 0;
      in_valid = 1'b1;
      a = v;
      flush = fl;
      do begin
         @(negedge clk);
         n++;
      end while (!(in_ready && ce) && n < 50);
      if (!(in_ready && ce)) chk("send_timeout", 0, 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      flush = 1'b0;
   endtask

   // Monitors: compare every held cycle (stability), pop on handshake.
   always @(negedge clk) begin
      if (!rst && out_valid) begin
         if (q.size() == 0) begin
            chk("unexpected_out_valid", 1, 0);
         end else begin
            chk("y", int'(y), q[0].y);
            chk("out_cnt", int'(out_cnt), q[0].cnt);
            chk("out_ovf", int'(out_ovf), q[0].ovf);
            if (ce && out_ready) void'(q.pop_front());
         end
      end
   end

   always @(negedge clk) begin
      if (!rst && out_valid14) begin
         if (q14.size() == 0) begin
            chk("unexpected_out_valid14", 1, 0);
         end else begin
            chk("y14", int'(y14), q14[0].y);
            chk("out_cnt14", int'(out_cnt14), q14[0].cnt);
            chk("out_ovf14", int'(out_ovf14), q14[0].ovf);
            if (ce) void'(q14.pop_front());
         end
      end
   end

   initial begin
      repeat (5000) @(posedge clk);
      $display("FAIL watchdog: simulation exceeded cycle budget");
      $fatal(1);
   end

   initial begin
      int samples[10] = '{118, 39, 28, 135, 197, 103, 55, 32, 71, 84};
      int n;

      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_in_ready", int'(in_ready), 1);
      chk("rst_y", int'(y), 0);
      chk("rst_out_cnt", int'(out_cnt), 0);
      chk("rst_out_ovf", int'(out_ovf), 0);

      // 14-bit accumulator, ten full-scale samples: overflow
`ifdef BLOCK_ACC_SAT_EN
      q14.push_back(mk(16383, 10, 1));
`else
      q14.push_back(mk((8191 * 10) % 16384, 10, 1));
`endif
      @(posedge clk);
      #1;
      for (int i = 0; i < 10; i++) begin
         in_valid14 = 1'b1;
         a14 = 13'd8191;
         n = 0;
         do begin
            @(negedge clk);
            n++;
         end while (!in_ready14 && n < 50);
         if (!in_ready14) chk("send14_timeout", 0, 1);
         @(posedge clk);
         #1;
         in_valid14 = 1'b0;
      end
      @(negedge clk);
      chk("ovf14_latency", int'(out_valid14), 1);
      @(posedge clk);
      #1;

      // Full block, consumer always ready: single pulse one cycle after 10th
      q.push_back(mk(862, 10, 0));
      for (int i = 0; i < 10; i++) send(13'(samples[i]), 1'b0);
      @(negedge clk);
      chk("blk_latency", int'(out_valid), 1);
      @(negedge clk);
      chk("blk_single_pulse", int'(out_valid), 0);
      @(posedge clk);
      #1;

      // Same block, consumer stalls 5 cycles; next sample and a flush wait
      out_ready = 1'b0;
      q.push_back(mk(862, 10, 0));
      for (int i = 0; i < 10; i++) send(13'(samples[i]), 1'b0);
      in_valid = 1'b1;
      a = 13'd100;
      flush = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("hold_in_ready", int'(in_ready), 0);
         chk("hold_out_valid", int'(out_valid), 1);
      end
      @(posedge clk);
      #1;
      flush = 1'b0;
      out_ready = 1'b1;

      // Stalled 100, then 200, 300, then flush of the partial block
      q.push_back(mk(600, 3, 0));
      send(13'd100, 1'b0);
      send(13'd200, 1'b0);
      send(13'd300, 1'b0);
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      repeat (3) @(posedge clk);
      #1;

      // Flush on an empty block produces nothing
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("empty_flush_no_out", int'(out_valid), 0);
      end
      @(posedge clk);
      #1;

      // Flush in the same cycle as an accepted sample includes that sample
      q.push_back(mk(15, 2, 0));
      send(13'd7, 1'b0);
      send(13'd8, 1'b1);
      repeat (3) @(posedge clk);
      #1;

      // Reset mid-block discards the partial sum
      for (int i = 0; i < 5; i++) send(13'd1, 1'b0);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("midrst_y", int'(y), 0);
      chk("midrst_out_cnt", int'(out_cnt), 0);
      chk("midrst_out_valid", int'(out_valid), 0);
      @(posedge clk);
      #1;

      // Ten ones with ce low for 3 cycles mid-block while a sample is offered
      q.push_back(mk(10, 10, 0));
      for (int i = 0; i < 4; i++) send(13'd1, 1'b0);
      in_valid = 1'b1;
      a = 13'd1;
      ce = 1'b0;
      repeat (3) @(posedge clk);
      #1 ce = 1'b1;
      for (int i = 0; i < 6; i++) send(13'd1, 1'b0);
      @(negedge clk);
      chk("ce_blk_latency", int'(out_valid), 1);

      repeat (4) @(posedge clk);
      @(negedge clk);
      chk("q_drained", q.size(), 0);
      chk("q14_drained", q14.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
